// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arb_pkg : MIPS opcode/funct constants, ALU operation bundle, NOP
// Revision 1.0
// ---------------------------------------------------------------------------
package alu_share_arb_pkg;

  localparam logic [5:0] INST_R     = 6'h00;
  localparam logic [5:0] INST_ADDIU = 6'h09;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rrs;
    logic [31:0] rrt;
  } alu_op_t;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  localparam alu_op_t NOP_OP = '{opcode: INST_R, funct: FUNCT_SLL, shamt: 5'd0,
                                 imm: 16'd0, rrs: 32'd0, rrt: 32'd0};

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_rsp_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_rsp_fifo : per-requester response FIFO with flush and occupancy output
// Revision 1.0
// ---------------------------------------------------------------------------
module alu_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] occ_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // flush wins over a coincident push so a dropped result never lands
  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & (occ_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (occ_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && !do_pop && (occ_q == CW'(DEPTH))));

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arb : shares one registered-output ALU between two requesters
// Revision 1.0
// ---------------------------------------------------------------------------
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter bit RR_EN      = 1'b1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush0_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [5:0]  req0_opcode_i,
  input  logic [5:0]  req0_funct_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [15:0] req0_imm_i,
  input  logic [31:0] req0_rrs_i,
  input  logic [31:0] req0_rrt_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [5:0]  req1_opcode_i,
  input  logic [5:0]  req1_funct_i,
  input  logic [4:0]  req1_shamt_i,
  input  logic [15:0] req1_imm_i,
  input  logic [31:0] req1_rrs_i,
  input  logic [31:0] req1_rrt_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_data_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_data_o,
  output logic [5:0]  alu_opcode_o,
  output logic [5:0]  alu_funct_o,
  output logic [4:0]  alu_shamt_o,
  output logic [15:0] alu_imm_o,
  output logic [31:0] alu_rrs_o,
  output logic [31:0] alu_rrt_o,
  input  logic [31:0] alu_rslt_i
);

  localparam int OCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + 2);

  tag_t           tag_q, tag_d;
  logic           rr_ptr_q, rr_ptr_d;
  logic [OCW-1:0] occ0, occ1;
  logic [CW-1:0]  cnt0, cnt1;
  logic           pop0, pop1, elig0, elig1, cand0, cand1;
  logic           gnt0, gnt1, issue, push0, push1;
  alu_op_t        op0, op1, alu_op;

  assign op0 = '{opcode: req0_opcode_i, funct: req0_funct_i, shamt: req0_shamt_i,
                 imm: req0_imm_i, rrs: req0_rrs_i, rrt: req0_rrt_i};
  assign op1 = '{opcode: req1_opcode_i, funct: req1_funct_i, shamt: req1_shamt_i,
                 imm: req1_imm_i, rrs: req1_rrs_i, rrt: req1_rrt_i};

  // credit = in-flight + buffered; a same-cycle pop frees a slot immediately
  assign pop0  = rsp0_valid_o & rsp0_ready_i;
  assign pop1  = rsp1_valid_o & rsp1_ready_i;
  assign cnt0  = CW'(occ0) + CW'(tag_q.valid & ~tag_q.id);
  assign cnt1  = CW'(occ1) + CW'(tag_q.valid & tag_q.id);
  assign elig0 = ((cnt0 - CW'(pop0)) < CW'(FIFO_DEPTH)) & ~flush0_i;
  assign elig1 = ((cnt1 - CW'(pop1)) < CW'(FIFO_DEPTH));
  assign cand0 = req0_valid_i & elig0;
  assign cand1 = req1_valid_i & elig1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (cand0 && cand1) begin
      if (RR_EN && rr_ptr_q) gnt1 = 1'b1;
      else                   gnt0 = 1'b1;
    end else begin
      gnt0 = cand0;
      gnt1 = cand1;
    end
    gnt0 = gnt0 & rst_n;
    gnt1 = gnt1 & rst_n;
  end

  assign issue        = gnt0 | gnt1;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;
  assign alu_op       = gnt1 ? op1 : (gnt0 ? op0 : NOP_OP);
  assign {alu_opcode_o, alu_funct_o, alu_shamt_o, alu_imm_o, alu_rrs_o, alu_rrt_o} = alu_op;

  // rr_ptr_q=1 means requester 1 wins the next tie
  assign tag_d    = '{valid: issue, id: gnt1};
  assign rr_ptr_d = issue ? gnt0 : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= '0;
      rr_ptr_q <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign push0 = tag_q.valid & ~tag_q.id & ~flush0_i;
  assign push1 = tag_q.valid & tag_q.id;

  alu_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0),
    .data_i  (alu_rslt_i),
    .pop_i   (rsp0_ready_i),
    .flush_i (flush0_i),
    .valid_o (rsp0_valid_o),
    .data_o  (rsp0_data_o),
    .occ_o   (occ0)
  );

  alu_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .data_i  (alu_rslt_i),
    .pop_i   (rsp1_ready_i),
    .flush_i (1'b0),
    .valid_o (rsp1_valid_o),
    .data_o  (rsp1_data_o),
    .occ_o   (occ1)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_share_arb : scoreboard bench for alu_share_arb with a registered ALU model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic    flush0 = 1'b0, req0_valid = 1'b0, req1_valid = 1'b0;
  logic    rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  alu_op_t op0 = NOP_OP, op1 = NOP_OP;
  logic    req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data, alu_rslt, alu_rrs, alu_rrt;
  logic [5:0]  alu_opcode, alu_funct;
  logic [4:0]  alu_shamt;
  logic [15:0] alu_imm;

  logic    fp_req0_valid = 1'b0, fp_req1_valid = 1'b0;
  logic    fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
  logic [31:0] fp_rsp0_data, fp_rsp1_data, fp_alu_rslt, fp_alu_rrs, fp_alu_rrt;
  logic [5:0]  fp_alu_opcode, fp_alu_funct;
  logic [4:0]  fp_alu_shamt;
  logic [15:0] fp_alu_imm;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  function automatic logic [31:0] alu_fn(input alu_op_t op);
    logic [31:0] r;
    r = 32'd0;
    if (op.opcode == INST_ADDIU) r = op.rrs + {{16{op.imm[15]}}, op.imm};
    else if (op.opcode == INST_R) begin
      case (op.funct)
        FUNCT_SLL:  r = op.rrt << op.shamt;
        FUNCT_ADDU: r = op.rrs + op.rrt;
        FUNCT_SUBU: r = op.rrs - op.rrt;
        FUNCT_AND:  r = op.rrs & op.rrt;
        FUNCT_OR:   r = op.rrs | op.rrt;
        default:    r = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic alu_op_t mk_r(input logic [5:0] funct, input logic [31:0] rs,
                                   input logic [31:0] rt);
    return '{opcode: INST_R, funct: funct, shamt: 5'd0, imm: 16'd0, rrs: rs, rrt: rt};
  endfunction

  function automatic alu_op_t mk_i(input logic [31:0] rs, input logic [15:0] imm);
    return '{opcode: INST_ADDIU, funct: 6'd0, shamt: 5'd0, imm: imm, rrs: rs, rrt: 32'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  alu_share_arb #(.RR_EN(1'b1), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush0_i(flush0),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_opcode_i(op0.opcode), .req0_funct_i(op0.funct), .req0_shamt_i(op0.shamt),
    .req0_imm_i(op0.imm), .req0_rrs_i(op0.rrs), .req0_rrt_i(op0.rrt),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_opcode_i(op1.opcode), .req1_funct_i(op1.funct), .req1_shamt_i(op1.shamt),
    .req1_imm_i(op1.imm), .req1_rrs_i(op1.rrs), .req1_rrt_i(op1.rrt),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready), .rsp0_data_o(rsp0_data),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready), .rsp1_data_o(rsp1_data),
    .alu_opcode_o(alu_opcode), .alu_funct_o(alu_funct), .alu_shamt_o(alu_shamt),
    .alu_imm_o(alu_imm), .alu_rrs_o(alu_rrs), .alu_rrt_o(alu_rrt), .alu_rslt_i(alu_rslt)
  );

  alu_share_arb #(.RR_EN(1'b0), .FIFO_DEPTH(FIFO_DEPTH)) dut_fp (
    .clk(clk), .rst_n(rst_n), .flush0_i(1'b0),
    .req0_valid_i(fp_req0_valid), .req0_ready_o(fp_req0_ready),
    .req0_opcode_i(op0.opcode), .req0_funct_i(op0.funct), .req0_shamt_i(op0.shamt),
    .req0_imm_i(op0.imm), .req0_rrs_i(op0.rrs), .req0_rrt_i(op0.rrt),
    .req1_valid_i(fp_req1_valid), .req1_ready_o(fp_req1_ready),
    .req1_opcode_i(op1.opcode), .req1_funct_i(op1.funct), .req1_shamt_i(op1.shamt),
    .req1_imm_i(op1.imm), .req1_rrs_i(op1.rrs), .req1_rrt_i(op1.rrt),
    .rsp0_valid_o(fp_rsp0_valid), .rsp0_ready_i(1'b1), .rsp0_data_o(fp_rsp0_data),
    .rsp1_valid_o(fp_rsp1_valid), .rsp1_ready_i(1'b1), .rsp1_data_o(fp_rsp1_data),
    .alu_opcode_o(fp_alu_opcode), .alu_funct_o(fp_alu_funct), .alu_shamt_o(fp_alu_shamt),
    .alu_imm_o(fp_alu_imm), .alu_rrs_o(fp_alu_rrs), .alu_rrt_o(fp_alu_rrt),
    .alu_rslt_i(fp_alu_rslt)
  );

  // registered ALU: result one cycle after the operation is presented
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rslt    <= '0;
      fp_alu_rslt <= '0;
    end else begin
      alu_rslt    <= alu_fn(alu_op_t'({alu_opcode, alu_funct, alu_shamt, alu_imm, alu_rrs, alu_rrt}));
      fp_alu_rslt <= alu_fn(alu_op_t'({fp_alu_opcode, fp_alu_funct, fp_alu_shamt, fp_alu_imm,
                                       fp_alu_rrs, fp_alu_rrt}));
    end
  end

  // scoreboard: expectations pushed at issue, compared at response handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else                chk("rsp0_data", rsp0_data, q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else                chk("rsp1_data", rsp1_data, q1.pop_front());
      end
      if (flush0) q0.delete();
      if (req0_valid && req0_ready) q0.push_back(alu_fn(op0));
      if (req1_valid && req1_ready) q1.push_back(alu_fn(op1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit n, input alu_op_t op);
    logic acc;
    acc = 1'b0;
    if (n) begin op1 = op; req1_valid = 1'b1; end
    else   begin op0 = op; req0_valid = 1'b1; end
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = n ? req1_ready : req0_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0) && !rsp0_valid && !rsp1_valid;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic single0(input alu_op_t op, input logic [31:0] exp, input string tag);
    rsp0_ready = 1'b0;
    send(1'b0, op);
    @(negedge clk);
    chk({tag, "_t1_valid"}, {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_t2_valid"}, {31'd0, rsp0_valid}, 32'd1);
    chk({tag, "_t2_data"}, rsp0_data, exp);
    tick();
    @(negedge clk);
    chk({tag, "_hold_data"}, rsp0_data, exp);
    tick();
    rsp0_ready = 1'b1;
    tick();
  endtask

  logic g0, g1, prev0, a, seen;
  int   k, k0, k1, acc;

  initial begin
    // reset state, including ready held low while a request is offered
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_alu_opcode", {26'd0, alu_opcode}, {26'd0, INST_R});
    chk("rst_alu_funct", {26'd0, alu_funct}, {26'd0, FUNCT_SLL});
    chk("rst_alu_rrs", alu_rrs, 32'd0);
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // single ADDIU 5 + (-1)
    single0(mk_i(32'd5, 16'hFFFF), 32'h4, "t1");
    drain();

    // both valid, round robin
    k0 = 0; k1 = 0; prev0 = 1'b0;
    op0 = mk_r(FUNCT_ADDU, 32'h100, 32'd1);
    op1 = mk_r(FUNCT_ADDU, 32'h200, 32'd2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      chk("t2_onehot", {31'd0, g0 ^ g1}, 32'd1);
      if (i > 0) chk("t2_alternate", {31'd0, g0}, {31'd0, ~prev0});
      prev0 = g0;
      tick();
      if (g0) begin k0++; op0 = mk_r(FUNCT_ADDU, 32'h100 + k0, 32'd1); end
      if (g1) begin k1++; op1 = mk_r(FUNCT_ADDU, 32'h200 + k1, 32'd2); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // fixed priority instance
    fp_req0_valid = 1'b1;
    fp_req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2fp_req0_ready", {31'd0, fp_req0_ready}, 32'd1);
      chk("t2fp_req1_ready", {31'd0, fp_req1_ready}, 32'd0);
      tick();
    end
    fp_req0_valid = 1'b0;
    @(negedge clk);
    chk("t2fp_req1_alone", {31'd0, fp_req1_ready}, 32'd1);
    tick();
    fp_req1_valid = 1'b0;

    // req1 stream against a stalled consumer: credit limit
    rsp1_ready = 1'b0;
    k = 1;
    acc = 0;
    op1 = mk_r(FUNCT_ADDU, 32'd1, 32'd1);
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = req1_ready;
      if (a) acc++;
      tick();
      if (a) begin k++; op1 = mk_r(FUNCT_ADDU, k, k); end
    end
    chk("t3_accepted", acc, FIFO_DEPTH);
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_ready", {31'd0, req1_ready}, 32'd1);
    chk("t3_first_data", rsp1_data, 32'd2);
    tick();
    req1_valid = 1'b0;
    drain();

    // full-rate stream: simultaneous push/pop each cycle
    rsp0_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      op0 = mk_r(FUNCT_ADDU, i, 3 * i);
      req0_valid = 1'b1;
      @(negedge clk);
      if (req0_ready) acc++;
      if (i >= 2) chk("t4_rsp_valid", {31'd0, rsp0_valid}, 32'd1);
      tick();
    end
    req0_valid = 1'b0;
    chk("t4_accepted", acc, 32'd100);
    drain();

    // flush0 one cycle after a req0 issue, req1 concurrent
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    send(1'b0, mk_r(FUNCT_SUBU, 32'd7, 32'd3));
    flush0 = 1'b1;
    op0 = mk_r(FUNCT_ADDU, 32'd9, 32'd9);
    req0_valid = 1'b1;
    op1 = mk_r(FUNCT_OR, 32'hF0, 32'h0F);
    req1_valid = 1'b1;
    @(negedge clk);
    chk("t5_req0_ready_flush", {31'd0, req0_ready}, 32'd0);
    chk("t5_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    flush0 = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_rsp0", {31'd0, rsp0_valid}, 32'd0);
      if (rsp1_valid) begin
        seen = 1'b1;
        chk("t5_rsp1_data", rsp1_data, 32'hFF);
      end
      tick();
    end
    chk("t5_rsp1_seen", {31'd0, seen}, 32'd1);
    drain();

    // asynchronous reset mid-stream
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    op0 = mk_r(FUNCT_ADDU, 32'd1, 32'd1);
    op1 = mk_r(FUNCT_ADDU, 32'd2, 32'd2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("t6_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("t6_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("t6_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("t6_rsp0_data", rsp0_data, 32'd0);
    chk("t6_rsp1_data", rsp1_data, 32'd0);
    chk("t6_alu_opcode", {26'd0, alu_opcode}, {26'd0, INST_R});
    chk("t6_alu_funct", {26'd0, alu_funct}, {26'd0, FUNCT_SLL});
    chk("t6_alu_rrs", alu_rrs, 32'd0);
    chk("t6_alu_rrt", alu_rrt, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("t6_post_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    tick();
    single0(mk_i(32'd10, 16'h0005), 32'd15, "t6");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    chk("watchdog", 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
